// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
//
// Two-stage pipelined bitwise logic unit with an internal accumulator for
// chained multi-operand reductions. Eight bitwise operations are selected per
// transaction. Input and output use valid/ready handshakes with full
// back-pressure.
//
// Optional feature (compile-time macro LOGIC_UNIT_POPCOUNT_EN):
//   adds out_popcount, the number of 1 bits in out_result, registered with it.
//
// Parameters:
//   WIDTH     operand/result width in bits (>= 1)
//   ACC_INIT  reset and clear value of the accumulator
//
// Ports:
//   clock         rising-edge clock
//   reset_n       asynchronous active-low reset
//   in_valid      input transaction valid
//   in_ready      unit can accept input this cycle
//   in_op         operation select:
//                   000 AND, 001 OR, 010 XOR, 011 NOR,
//                   100 NAND, 101 XNOR, 110 ANDN (A & ~B), 111 PASSA
//   in_a          operand A
//   in_b          operand B
//   in_chain      use accumulator in place of in_a
//   in_clear      load ACC_INIT into accumulator before A is selected
//   out_valid     result valid
//   out_ready     downstream accepts result
//   out_result    operation result
//   out_popcount  number of 1 bits in out_result (optional)
//   out_zero      out_result == 0
// -----------------------------------------------------------------------------
module logic_unit_pipe #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [2:0]                  in_op,
    input  logic [WIDTH-1:0]            in_a,
    input  logic [WIDTH-1:0]            in_b,
    input  logic                        in_chain,
    input  logic                        in_clear,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_result,
`ifdef LOGIC_UNIT_POPCOUNT_EN
    output logic [$clog2(WIDTH+1)-1:0]  out_popcount,
`endif
    output logic                        out_zero
);

    typedef enum logic [2:0] {
        OpAnd   = 3'b000,
        OpOr    = 3'b001,
        OpXor   = 3'b010,
        OpNor   = 3'b011,
        OpNand  = 3'b100,
        OpXnor  = 3'b101,
        OpAndn  = 3'b110,
        OpPassA = 3'b111
    } op_e;

    function automatic logic [WIDTH-1:0] f_logic_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] res;
        res = '0;
        unique case (op_e'(op))
            OpAnd:   res = a & b;
            OpOr:    res = a | b;
            OpXor:   res = a ^ b;
            OpNor:   res = ~(a | b);
            OpNand:  res = ~(a & b);
            OpXnor:  res = ~(a ^ b);
            OpAndn:  res = a & ~b;
            OpPassA: res = a;
        endcase
        return res;
    endfunction

`ifdef LOGIC_UNIT_POPCOUNT_EN
    localparam int unsigned PCW = $clog2(WIDTH + 1);

    function automatic logic [PCW-1:0] f_popcount(input logic [WIDTH-1:0] v);
        logic [PCW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + PCW'(v[i]);
        end
        return cnt;
    endfunction
`endif

    // Stage 1: captured transaction
    logic             r_s1_valid;
    logic [2:0]       r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s1_chain;
    logic             r_s1_clear;

    // Stage 2: registered result
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
`ifdef LOGIC_UNIT_POPCOUNT_EN
    logic [PCW-1:0]   r_popcount;
`endif

    logic [WIDTH-1:0] r_acc;

    logic             w_s2_free;
    logic             w_s1_move;
    logic             w_in_fire;
    logic [WIDTH-1:0] w_eff_a;
    logic [WIDTH-1:0] w_result;

    // Flow control. in_ready is combinational from out_ready so a full,
    // draining pipe keeps accepting without a bubble.
    assign w_s2_free = ~r_s2_valid | out_ready;
    assign w_s1_move = r_s1_valid & w_s2_free;
    assign in_ready  = ~r_s1_valid | w_s1_move;
    assign w_in_fire = in_valid & in_ready;

    // Effective A. The accumulator always holds the newest result to enter
    // S2, and the result is computed at the S2 load, so a chained op sitting
    // in S1 sees its predecessor's result without any stall.
    always_comb begin
        w_eff_a = r_s1_a;
        if (r_s1_chain) begin
            w_eff_a = r_s1_clear ? ACC_INIT : r_acc;
        end
    end

    assign w_result = f_logic_op(r_s1_op, w_eff_a, r_s1_b);

    // Stage 1 valid
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
        end else if (w_s1_move) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 1 payload
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_op    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_chain <= 1'b0;
            r_s1_clear <= 1'b0;
        end else if (w_in_fire) begin
            r_s1_op    <= in_op;
            r_s1_a     <= in_a;
            r_s1_b     <= in_b;
            r_s1_chain <= in_chain;
            r_s1_clear <= in_clear;
        end
    end

    // Stage 2 valid: filled by an S1 transfer, emptied by a downstream accept
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
        end else if (w_s1_move) begin
            r_s2_valid <= 1'b1;
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    // Stage 2 result; held while stalled
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_result <= '0;
            r_zero   <= 1'b1;
        end else if (w_s1_move) begin
            r_result <= w_result;
            r_zero   <= ~|w_result;
        end
    end

`ifdef LOGIC_UNIT_POPCOUNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_popcount <= '0;
        end else if (w_s1_move) begin
            r_popcount <= f_popcount(w_result);
        end
    end

    assign out_popcount = r_popcount;
`endif

    // Accumulator: a clear is subsumed here because the write-back of the
    // new result overwrites the cleared value in the same transfer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= ACC_INIT;
        end else if (w_s1_move) begin
            r_acc <= w_result;
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_result = r_result;
    assign out_zero   = r_zero;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// tb_logic_unit_pipe
//
// Self-checking bench for logic_unit_pipe (WIDTH=32, non-zero ACC_INIT).
// A transaction-level reference model tracks accepted-but-not-emitted results
// in a queue, computing each result from per-op truth tables at accept time.
// -----------------------------------------------------------------------------
module tb_logic_unit_pipe;

    localparam int unsigned  W        = 32;
    localparam logic [W-1:0] ACC_INIT = 32'h5A00_00C3;
    localparam int unsigned  PCW      = $clog2(W + 1);

    logic          clock;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_chain;
    logic          in_clear;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic          out_zero;
`ifdef LOGIC_UNIT_POPCOUNT_EN
    logic [PCW-1:0] out_popcount;
`endif

    logic_unit_pipe #(
        .WIDTH    (W),
        .ACC_INIT (ACC_INIT)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_chain     (in_chain),
        .in_clear     (in_clear),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
`ifdef LOGIC_UNIT_POPCOUNT_EN
        .out_popcount (out_popcount),
`endif
        .out_zero     (out_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [W-1:0] res;
        logic         has_k;
        logic [W-1:0] k;
    } exp_t;

    exp_t          q[$];
    logic [W-1:0]  m_acc;
    logic          last_acc;
    int            n_checks;
    int            n_errors;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Per-op truth table, bit index = {a_bit, b_bit}
    function automatic logic [W-1:0] model_op(input logic [2:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        logic [3:0] tt [8];
        logic [3:0] t;
        logic [W-1:0] r;
        tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0001;
        tt[4] = 4'b0111; tt[5] = 4'b1001; tt[6] = 4'b0100; tt[7] = 4'b1100;
        t = tt[op];
        for (int i = 0; i < W; i++) begin
            r[i] = t[{a[i], b[i]}];
        end
        return r;
    endfunction

    // One cycle: called just after a falling edge, returns after the next one.
    task automatic step(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic ch, input logic cl,
                        input logic ordy, input logic has_k, input logic [W-1:0] k,
                        output logic accepted);
        logic         exp_rdy;
        logic         exp_ov;
        logic [W-1:0] ea;
        exp_t         e;
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_chain  = ch;
        in_clear  = cl;
        out_ready = ordy;
        #1;
        // Two slots: ready drops only with both full and the output stalled
        exp_rdy = !(q.size() == 2 && !ordy);
        exp_ov  = (q.size() == 2) || (q.size() == 1 && !last_acc);
        check_eq("in_ready", 64'(in_ready), 64'(exp_rdy));
        check_eq("out_valid", 64'(out_valid), 64'(exp_ov));
        if (exp_ov) begin
            check_eq("out_result", 64'(out_result), 64'(q[0].res));
            check_eq("out_zero", 64'(out_zero), 64'(q[0].res == '0));
            if (q[0].has_k) check_eq("out_result_const", 64'(out_result), 64'(q[0].k));
`ifdef LOGIC_UNIT_POPCOUNT_EN
            check_eq("out_popcount", 64'(out_popcount), 64'($countones(q[0].res)));
`endif
            if (ordy) void'(q.pop_front());
        end
        accepted = v && exp_rdy;
        if (accepted) begin
            ea      = ch ? (cl ? ACC_INIT : m_acc) : a;
            e.res   = model_op(op, ea, b);
            e.has_k = has_k;
            e.k     = k;
            m_acc   = e.res;
            q.push_back(e);
        end
        last_acc = accepted;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0, acc);
    endtask

    // Assert reset away from the clock edge and check the async effect.
    task automatic do_reset();
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_result", 64'(out_result), 64'd0);
        check_eq("rst_out_zero", 64'(out_zero), 64'd1);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef LOGIC_UNIT_POPCOUNT_EN
        check_eq("rst_popcount", 64'(out_popcount), 64'd0);
`endif
        q.delete();
        m_acc    = ACC_INIT;
        last_acc = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    logic [W-1:0] ops_k [8];
    logic [W-1:0] bp_b  [3];

    initial begin
        logic acc;
        int   idx;
        n_checks  = 0;
        n_errors  = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        in_chain  = 1'b0;
        in_clear  = 1'b0;
        out_ready = 1'b1;
        m_acc     = ACC_INIT;
        last_acc  = 1'b0;

        @(negedge clock);
        do_reset();
        idle(1);

        // Basic OR, two-cycle latency
        step(1'b1, 3'b001, 32'hF0F0_0000, 32'h0000_0F0F, 1'b0, 1'b0, 1'b1, 1'b1,
             32'hF0F0_0F0F, acc);
        idle(3);

        // All eight ops back to back
        ops_k[0] = 32'hFF00_0000; ops_k[1] = 32'hFFFF_FF00;
        ops_k[2] = 32'h00FF_FF00; ops_k[3] = 32'h0000_00FF;
        ops_k[4] = 32'h00FF_FFFF; ops_k[5] = 32'hFF00_00FF;
        ops_k[6] = 32'h00FF_0000; ops_k[7] = 32'hFFFF_0000;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 3'(i), 32'hFFFF_0000, 32'hFF00_FF00, 1'b0, 1'b0, 1'b1, 1'b1,
                 ops_k[i], acc);
        end
        idle(3);

        // Chained OR starting from a clear
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 3'b001, 32'hFFFF_FFFF, W'(1) << i, 1'b1, (i == 0), 1'b1, 1'b1,
                 ACC_INIT | ((W'(2) << i) - W'(1)), acc);
            check_eq("chain_accept", 64'(acc), 64'd1);
        end
        idle(3);

        // Back-pressure: three inputs, output stalled for five cycles
        bp_b[0] = 32'h0000_0011; bp_b[1] = 32'h0000_2200; bp_b[2] = 32'h0033_0000;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            step(idx < 3, 3'b010, 32'h1234_5678, bp_b[idx % 3], 1'b0, 1'b0, 1'b0, 1'b0,
                 '0, acc);
            if (acc) idx++;
        end
        check_eq("bp_accepted_while_stalled", 64'(idx), 64'd2);
        for (int c = 0; c < 10; c++) begin
            step(idx < 3, 3'b010, 32'h1234_5678, bp_b[idx % 3], 1'b0, 1'b0, 1'b1, 1'b0,
                 '0, acc);
            if (acc) idx++;
        end
        check_eq("bp_all_accepted", 64'(idx), 64'd3);
        check_eq("bp_drained", 64'(q.size()), 64'd0);

        // Zero flag
        step(1'b1, 3'b010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b1, '0, acc);
        idle(3);

        // Reset with two transactions in flight
        step(1'b1, 3'b001, 32'h0F00_0000, 32'h0000_00F0, 1'b0, 1'b0, 1'b0, 1'b0, '0, acc);
        step(1'b1, 3'b000, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, '0, acc);
        check_eq("inflight_before_reset", 64'(q.size()), 64'd2);
        do_reset();
        step(1'b1, 3'b111, 32'h1111_1111, 32'h2222_2222, 1'b1, 1'b0, 1'b1, 1'b1, ACC_INIT,
             acc);
        idle(3);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? ra : W'($urandom);
            step($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), ra, rb,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 9) < 6, 1'b0, '0, acc);
            if (c == 300) do_reset();
        end
        idle(4);
        check_eq("final_drained", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
